// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants
package cpu_pkg;
  typedef enum logic [1:0] {PC_BR = 2'd0, PC_JAL = 2'd1, PC_JALR = 2'd2} pc_sel_t;
  typedef enum logic {RUN, HALT} fetch_state_t;
  localparam logic [31:0] INSTR_NOP = 32'h00000013;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with push/pop/flush and occupancy count
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with credit-limited imem requests,
// instruction buffer, and redirect handling with in-flight response kill
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int n = 32,
  parameter int alen = 6,
  parameter int QDEPTH = 2,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect,
  input  pc_sel_t         redirect_sel,
  input  logic [n-1:0]    redirect_base,
  input  logic [12:0]     brimm,
  input  logic [20:0]     jalimm,
  input  logic [11:0]     jalrimm,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [alen-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [n-1:0]    imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [n-1:0]    if_instr,
  output logic [n-1:0]    if_pc,
  output logic [n-1:0]    if_pc4,
  output logic            misalign
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0] QD = (CW+1)'(QDEPTH);
  fetch_state_t st;
  logic [n-1:0] fpc, target, q_pc;
  logic [CW-1:0] b_cnt, q_cnt, drop;
  logic redir, req_fire, push, pop;
  assign redir = redirect & (st == RUN);
  assign target = redirect_sel == PC_BR  ? redirect_base + {{(n-13){brimm[12]}}, brimm} :
                  redirect_sel == PC_JAL ? redirect_base + {{(n-21){jalimm[20]}}, jalimm} :
                  (redirect_base + {{(n-12){jalrimm[11]}}, jalrimm}) & {{(n-1){1'b1}}, 1'b0};
  // reset gates the request so nothing is offered while the memory is also in reset
  assign imem_req_valid = reset & (st == RUN) & ~redirect & ({1'b0, q_cnt} + {1'b0, b_cnt} < QD);
  assign req_fire = imem_req_valid & imem_req_ready;
  assign imem_addr = fpc[alen+1:2];
  assign push = imem_rsp_valid & (drop == '0) & ~redir;
  assign if_valid = (st == RUN) & ~redirect & (b_cnt != '0);
  assign pop = if_valid & if_ready;
  assign if_pc4 = if_pc + n'(4);
  assign misalign = st == HALT;
  // the PC queue keeps every outstanding request, stale or not, so its count is the in-flight total
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      st <= RUN;
      fpc <= RESET_PC;
      drop <= '0;
    end else if (redir) begin
      drop <= q_cnt - CW'(imem_rsp_valid);
      if (target[1]) st <= HALT;
      else fpc <= target;
    end else begin
      if (req_fire) fpc <= fpc + n'(4);
      if (imem_rsp_valid && drop != '0) drop <= drop - CW'(1);
    end
  fetch_fifo #(.WIDTH(2*n), .DEPTH(QDEPTH)) u_buf (
    .clock(clock), .reset(reset), .push(push), .pop(pop), .flush(redir),
    .din({imem_rsp_data, q_pc}), .dout({if_instr, if_pc}), .count(b_cnt)
  );
  fetch_fifo #(.WIDTH(n), .DEPTH(QDEPTH)) u_pcq (
    .clock(clock), .reset(reset), .push(req_fire), .pop(imem_rsp_valid), .flush(1'b0),
    .din(fpc), .dout(q_pc), .count(q_cnt)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized checks of fetch_unit against a queue-based reference model
module tb_fetch_unit;
  import cpu_pkg::*;
  localparam int QD = 2;
  logic clock = 0, reset = 0;
  logic redirect = 0;
  pc_sel_t redirect_sel = PC_BR;
  logic [31:0] redirect_base = 0;
  logic [12:0] brimm = 0;
  logic [20:0] jalimm = 0;
  logic [11:0] jalrimm = 0;
  logic imem_req_valid, imem_req_ready = 1;
  logic [5:0] imem_addr;
  logic imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic if_valid, if_ready = 1, misalign;
  logic [31:0] if_instr, if_pc, if_pc4;

  fetch_unit dut (
    .clock(clock), .reset(reset), .redirect(redirect), .redirect_sel(redirect_sel),
    .redirect_base(redirect_base), .brimm(brimm), .jalimm(jalimm), .jalrimm(jalrimm),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc4(if_pc4), .misalign(misalign)
  );

  always #5 clock = ~clock;

  typedef struct {logic [31:0] pc; bit stale; int due;} ent_t;
  ent_t pq[$];
  logic [31:0] bq[$];
  logic [31:0] mem [64];
  logic [31:0] fpc_m;
  bit halted, rand_rdy;
  int cyc, lat_lo, lat_hi, checks, errors;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tgt(pc_sel_t s, logic [31:0] b, logic [12:0] bi,
                                      logic [20:0] ji, logic [11:0] jri);
    return s == PC_BR  ? b + 32'($signed(bi)) :
           s == PC_JAL ? b + 32'($signed(ji)) : (b + 32'($signed(jri))) & ~32'd1;
  endfunction

  // one clock cycle: entered and left 1 time unit after a rising edge
  task automatic tick();
    bit ev_req, ev_if, redir_eff;
    logic [31:0] t;
    ent_t e;
    int lat;
    imem_req_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    imem_rsp_valid = pq.size() > 0 && pq[0].due <= cyc;
    imem_rsp_data = imem_rsp_valid ? mem[pq[0].pc[7:2]] : $urandom;
    #4;
    redir_eff = redirect && !halted;
    ev_req = !halted && !redirect && (pq.size() + bq.size() < QD);
    ev_if = !halted && !redirect && bq.size() > 0;
    chk("req_valid", imem_req_valid, ev_req);
    chk("if_valid", if_valid, ev_if);
    chk("misalign", misalign, halted);
    if (ev_req) chk("imem_addr", imem_addr, fpc_m[7:2]);
    if (ev_if) begin
      chk("if_pc", if_pc, bq[0]);
      chk("if_pc4", if_pc4, bq[0] + 32'd4);
      chk("if_instr", if_instr, mem[bq[0][7:2]]);
    end
    if (ev_if && if_ready) void'(bq.pop_front());
    if (imem_rsp_valid) begin
      e = pq.pop_front();
      if (!e.stale && !redir_eff) bq.push_back(e.pc);
    end
    if (redir_eff) begin
      bq.delete();
      foreach (pq[i]) pq[i].stale = 1;
      t = tgt(redirect_sel, redirect_base, brimm, jalimm, jalrimm);
      if (t[1]) halted = 1;
      else fpc_m = t;
    end
    if (ev_req && imem_req_ready) begin
      lat = $urandom_range(lat_lo, lat_hi);
      pq.push_back('{fpc_m, 1'b0, cyc + lat});
      fpc_m += 32'd4;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic redir(pc_sel_t s, logic [31:0] b, logic [12:0] bi, logic [20:0] ji, logic [11:0] jri);
    redirect = 1;
    redirect_sel = s;
    redirect_base = b;
    brimm = bi;
    jalimm = ji;
    jalrimm = jri;
    tick();
    redirect = 0;
  endtask

  task automatic rst_pulse();
    reset = 0;
    redirect = 0;
    imem_rsp_valid = 0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_misalign", misalign, 0);
    pq.delete();
    bq.delete();
    fpc_m = 0;
    halted = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1;
  endtask

  initial begin
    logic [31:0] b;
    for (int i = 0; i < 63; i++) mem[i] = $urandom;
    mem[63] = INSTR_NOP;
    lat_lo = 1;
    lat_hi = 1;
    rand_rdy = 0;
    @(posedge clock);
    #1;
    rst_pulse();
    repeat (8) tick();
    rst_pulse();
    if_ready = 0;
    repeat (6) tick();
    if_ready = 1;
    repeat (6) tick();
    rst_pulse();
    lat_lo = 3;
    lat_hi = 3;
    repeat (2) tick();
    redir(PC_BR, 32'h10, 13'h1FF8, 21'h0, 12'h0);
    repeat (8) tick();
    rst_pulse();
    lat_lo = 1;
    lat_hi = 2;
    repeat (3) tick();
    redir(PC_JALR, 32'h21, 13'h0, 21'h0, 12'h003);
    repeat (6) tick();
    redir(PC_JALR, 32'h20, 13'h0, 21'h0, 12'h002);
    repeat (6) tick();
    rst_pulse();
    lat_lo = 1;
    lat_hi = 1;
    repeat (2) tick();
    redir(PC_JAL, 32'h30, 13'h0, 21'h10, 12'h0);
    repeat (6) tick();
    lat_lo = 3;
    lat_hi = 3;
    rst_pulse();
    repeat (2) tick();
    rst_pulse();
    repeat (6) tick();
    rand_rdy = 1;
    lat_lo = 1;
    lat_hi = 4;
    for (int k = 0; k < 800; k++) begin
      if_ready = $urandom_range(0, 3) != 0;
      if ((halted && $urandom_range(0, 5) == 0) || $urandom_range(0, 199) == 0) rst_pulse();
      else if ($urandom_range(0, 12) == 0) begin
        b = $urandom;
        if ($urandom_range(0, 7) != 0) b[1:0] = 2'b00;
        redir(pc_sel_t'($urandom_range(0, 2)), b, 13'($urandom) & 13'h1FFC,
              21'($urandom) & 21'h1FFFFC, 12'($urandom) & 12'hFFC);
      end else tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
